// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared types and constants for the serial adder front end.
//   ser_state_e   : operand shifter FSM states (S_IDLE, S_SHIFT)
//   DEFAULT_WIDTH : default operand width in bits
//   cnt_width()   : width of a bit counter that must reach w-1 (min 1 bit)
// -----------------------------------------------------------------------------
package serial_adder_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } ser_state_e;

    localparam int DEFAULT_WIDTH = 8;

    // $clog2(1) is 0, so a one-bit operand still gets a one-bit counter.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_piso_reg.sv
// -----------------------------------------------------------------------------
// serial_piso_reg
// Parallel-in, serial-out shift register, LSB first, zero fill from the top.
// Ports:
//   clk    in   1      rising-edge clock
//   reset  in   1      asynchronous active-high clear
//   load   in   1      capture d (takes priority over shift)
//   shift  in   1      shift right by one bit
//   d      in   WIDTH  parallel load data
//   q_lsb  out  1      current serial bit (register bit 0)
// -----------------------------------------------------------------------------
module serial_piso_reg
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             q_lsb
);

    logic [WIDTH-1:0] r_sr;

    // A logical right shift zero-fills the MSB and also works for WIDTH=1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sr <= '0;
        end else if (load) begin
            r_sr <= d;
        end else if (shift) begin
            r_sr <= r_sr >> 1;
        end
    end

    assign q_lsb = r_sr[0];

endmodule

// File: rtl/serial_operand_shifter.sv
// -----------------------------------------------------------------------------
// serial_operand_shifter
// Feeds a serial adder: accepts two WIDTH-bit operands through a valid/ready
// handshake and streams them out LSB first, one bit pair per clock, marking
// the first bit (carry clear) and the last bit (result close).
// Optional feature macro: SERIAL_STALL_EN (adds the stall input).
// Ports:
//   clk         in   1      rising-edge clock
//   reset       in   1      asynchronous active-high reset
//   load_valid  in   1      a_in/b_in valid this cycle
//   load_ready  out  1      operand pair can be accepted this cycle
//   a_in, b_in  in   WIDTH  parallel operands
//   a_bit,b_bit out  1      current serial bit pair
//   bit_valid   out  1      a_bit/b_bit meaningful this cycle
//   first_bit   out  1      bit 0 is being presented
//   last_bit    out  1      bit WIDTH-1 is being presented
//   stall       in   1      (SERIAL_STALL_EN only) freeze the stream
// -----------------------------------------------------------------------------
module serial_operand_shifter
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             a_bit,
    output logic             b_bit,
    output logic             bit_valid,
    output logic             first_bit,
    output logic             last_bit
`ifdef SERIAL_STALL_EN
    ,
    input  logic             stall
`endif
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    ser_state_e       r_state;
    ser_state_e       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;

    logic w_stall;
    logic w_in_shift;
    logic w_at_last;
    logic w_advance;
    logic w_accept;
    logic w_a_lsb;
    logic w_b_lsb;

`ifdef SERIAL_STALL_EN
    // Stall only has meaning while streaming; in S_IDLE it is masked below.
    assign w_stall = stall;
`else
    assign w_stall = 1'b0;
`endif

    assign w_in_shift = (r_state == S_SHIFT);
    assign w_at_last  = w_in_shift && (r_cnt == CNT_LAST);
    assign w_advance  = w_in_shift && !w_stall;

    // Ready on the last bit lets the next pair load in the same edge that
    // retires the current one, so back-to-back streams have no bubble.
    assign load_ready = (r_state == S_IDLE) || (w_at_last && !w_stall);
    assign w_accept   = load_ready && load_valid;

    serial_piso_reg #(.WIDTH(WIDTH)) u_piso_a (
        .clk   (clk),
        .reset (reset),
        .load  (w_accept),
        .shift (w_advance),
        .d     (a_in),
        .q_lsb (w_a_lsb)
    );

    serial_piso_reg #(.WIDTH(WIDTH)) u_piso_b (
        .clk   (clk),
        .reset (reset),
        .load  (w_accept),
        .shift (w_advance),
        .d     (b_in),
        .q_lsb (w_b_lsb)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (load_valid) begin
                    w_state_next = S_SHIFT;
                    w_cnt_next   = '0;
                end
            end
            S_SHIFT: begin
                if (!w_stall) begin
                    if (r_cnt == CNT_LAST) begin
                        // Counter never runs past WIDTH-1: it restarts for a
                        // chained pair or parks at zero for idle.
                        w_cnt_next   = '0;
                        w_state_next = load_valid ? S_SHIFT : S_IDLE;
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Stream outputs are gated by state so idle always presents zeros.
    // When stalled, state/cnt/shift regs hold, so the bit values and flags
    // hold too; only bit_valid drops.
    assign bit_valid = w_advance;
    assign a_bit     = w_in_shift && w_a_lsb;
    assign b_bit     = w_in_shift && w_b_lsb;
    assign first_bit = w_in_shift && (r_cnt == '0);
    assign last_bit  = w_at_last;

endmodule

// File: tb/tb_serial_operand_shifter.sv
// -----------------------------------------------------------------------------
// tb_serial_operand_shifter
// Self-checking bench for serial_operand_shifter: an 8-bit instance covers
// directed streams, back-to-back loads, ignored loads, async reset and a
// random run against a bit-index reference model; a 1-bit instance covers
// the single-bit corner. The stall sequence builds with SERIAL_STALL_EN.
// -----------------------------------------------------------------------------
module tb_serial_operand_shifter;

    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         lv;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         load_ready, a_bit, b_bit, bit_valid, first_bit, last_bit;

    logic         lv1;
    logic [0:0]   a1, b1;
    logic         ready1, abit1, bbit1, valid1, first1, last1;

`ifdef SERIAL_STALL_EN
    logic         stall;
`endif

    serial_operand_shifter #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (lv),
        .load_ready (load_ready),
        .a_in       (a_in),
        .b_in       (b_in),
        .a_bit      (a_bit),
        .b_bit      (b_bit),
        .bit_valid  (bit_valid),
        .first_bit  (first_bit),
        .last_bit   (last_bit)
`ifdef SERIAL_STALL_EN
        ,
        .stall      (stall)
`endif
    );

    serial_operand_shifter #(.WIDTH(1)) dut1 (
        .clk        (clk),
        .reset      (reset),
        .load_valid (lv1),
        .load_ready (ready1),
        .a_in       (a1),
        .b_in       (b1),
        .a_bit      (abit1),
        .b_bit      (bbit1),
        .bit_valid  (valid1),
        .first_bit  (first1),
        .last_bit   (last1)
`ifdef SERIAL_STALL_EN
        ,
        .stall      (stall)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Check every output of the 8-bit instance.
    task automatic chk_all(input string tag, input logic ev, input logic ea,
                           input logic eb, input logic ef, input logic el,
                           input logic er);
        chk($sformatf("%s bit_valid", tag),  bit_valid,  ev);
        chk($sformatf("%s a_bit", tag),      a_bit,      ea);
        chk($sformatf("%s b_bit", tag),      b_bit,      eb);
        chk($sformatf("%s first_bit", tag),  first_bit,  ef);
        chk($sformatf("%s last_bit", tag),   last_bit,   el);
        chk($sformatf("%s load_ready", tag), load_ready, er);
    endtask

    // exp_a/exp_b list the serial bits in stream order: leftmost = cycle 1.
    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_a;
        logic [W-1:0] exp_b;
    } vec_t;

    vec_t tbl [5];

    // Load one pair from idle and check all W cycles plus the return to idle.
    // inject_c > 0 raises load_valid with 8'h12 during that (busy) cycle.
    task automatic run_stream(input vec_t v, input int inject_c, input string tag);
        @(negedge clk);
        chk_all($sformatf("%s idle", tag), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        lv   = 1'b1;
        a_in = v.a;
        b_in = v.b;
        for (int c = 1; c <= W; c++) begin
            @(posedge clk);
            #1;
            lv = (c == inject_c);
            if (c == inject_c) begin
                a_in = 8'h12;
                b_in = 8'h12;
            end
            @(negedge clk);
            chk_all($sformatf("%s c%0d", tag, c), 1'b1, v.exp_a[W-c], v.exp_b[W-c],
                    (c == 1), (c == W), (c == W));
        end
        @(posedge clk);
        #1;
        lv = 1'b0;
        @(negedge clk);
        chk_all($sformatf("%s done", tag), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        $display("stream %s a=%02h b=%02h streamed", tag, v.a, v.b);
    endtask

    // Reference model state: which operand pair is on the wire and at what bit.
    bit           m_busy;
    int           m_k;
    logic [W-1:0] m_a, m_b;

    initial begin
        #300000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{8'hA5, 8'h3C, 8'b10100101, 8'b00111100};
        tbl[1] = '{8'h01, 8'h80, 8'b10000000, 8'b00000001};
        tbl[2] = '{8'hF0, 8'h0F, 8'b00001111, 8'b11110000};
        tbl[3] = '{8'h12, 8'h6B, 8'b01001000, 8'b11010110};
        tbl[4] = '{8'hFF, 8'h00, 8'b11111111, 8'b00000000};

        reset = 1'b1;
        lv    = 1'b0;
        a_in  = '0;
        b_in  = '0;
        lv1   = 1'b0;
        a1    = '0;
        b1    = '0;
`ifdef SERIAL_STALL_EN
        stall = 1'b0;
`endif

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("reset w1 ready", ready1, 1'b1);
        chk("reset w1 valid", valid1, 1'b0);
        reset = 1'b0;

        // Table-driven single streams
        for (int i = 0; i < 5; i++) begin
            run_stream(tbl[i], 0, $sformatf("tbl%0d", i));
        end

        // Load while busy in cycle 4 is ignored
        run_stream(tbl[0], 4, "busyload");

        // Back-to-back streams with load_valid held high
        @(negedge clk);
        chk("b2b start ready", load_ready, 1'b1);
        lv   = 1'b1;
        a_in = 8'hFF;
        b_in = 8'h01;
        for (int c = 1; c <= 17; c++) begin
            @(posedge clk);
            #1;
            if (c == 8) begin
                a_in = 8'h00;
                b_in = 8'hFF;
            end
            if (c == 9) lv = 1'b0;
            @(negedge clk);
            if (c <= 16) begin
                chk_all($sformatf("b2b c%0d", c), 1'b1, (c <= 8),
                        (c <= 8) ? (c == 1) : 1'b1,
                        (c == 1 || c == 9), (c == 8 || c == 16), (c == 8 || c == 16));
            end else begin
                chk_all("b2b idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            end
        end
        $display("stream b2b FF/01 then 00/FF streamed");

        // Asynchronous reset in the middle of cycle 5
        @(negedge clk);
        lv   = 1'b1;
        a_in = 8'hA5;
        b_in = 8'h3C;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk);
            #1;
            lv = 1'b0;
            @(negedge clk);
        end
        chk("pre-reset bit_valid", bit_valid, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        chk_all("async reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        reset = 1'b0;
        $display("async reset applied in cycle 5");
        run_stream(tbl[0], 0, "postreset");

        // WIDTH=1 instance
        @(negedge clk);
        chk("w1 idle ready", ready1, 1'b1);
        lv1 = 1'b1;
        a1  = 1'b1;
        b1  = 1'b1;
        @(posedge clk);
        #1;
        lv1 = 1'b0;
        @(negedge clk);
        chk("w1 valid", valid1, 1'b1);
        chk("w1 first", first1, 1'b1);
        chk("w1 last", last1, 1'b1);
        chk("w1 a_bit", abit1, 1'b1);
        chk("w1 b_bit", bbit1, 1'b1);
        chk("w1 ready", ready1, 1'b1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("w1 idle valid", valid1, 1'b0);
        lv1 = 1'b1;
        a1  = 1'b1;
        b1  = 1'b0;
        @(posedge clk);
        #1;
        a1 = 1'b0;
        b1 = 1'b1;
        @(negedge clk);
        chk("w1 b2b0 a_bit", abit1, 1'b1);
        chk("w1 b2b0 b_bit", bbit1, 1'b0);
        chk("w1 b2b0 first", first1, 1'b1);
        @(posedge clk);
        #1;
        lv1 = 1'b0;
        @(negedge clk);
        chk("w1 b2b1 valid", valid1, 1'b1);
        chk("w1 b2b1 a_bit", abit1, 1'b0);
        chk("w1 b2b1 b_bit", bbit1, 1'b1);
        chk("w1 b2b1 last", last1, 1'b1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("w1 end valid", valid1, 1'b0);
        $display("stream width1 checked");

`ifdef SERIAL_STALL_EN
        // Stall during cycles 3-4 of the A5/3C stream
        begin
            logic [W-1:0] ta, tb;
            int           idx;
            ta = 8'hA5;
            tb = 8'h3C;
            @(negedge clk);
            lv   = 1'b1;
            a_in = ta;
            b_in = tb;
            for (int c = 1; c <= 11; c++) begin
                @(posedge clk);
                #1;
                lv    = 1'b0;
                stall = (c == 3 || c == 4);
                @(negedge clk);
                idx = (c <= 2) ? c - 1 : ((c <= 4) ? 2 : c - 3);
                if (c <= 10) begin
                    chk_all($sformatf("stall c%0d", c), !(c == 3 || c == 4),
                            ta[idx], tb[idx], (idx == 0), (idx == W - 1), (c == 10));
                end else begin
                    chk_all("stall idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
                end
            end
            stall = 1'b0;
            $display("stream stall A5/3C checked");
        end
`endif

        // Random traffic against the bit-index model
        m_busy = 1'b0;
        m_k    = 0;
        m_a    = '0;
        m_b    = '0;
        for (int i = 0; i < 400; i++) begin
            bit m_ready;
            @(negedge clk);
            if (m_busy) begin
                chk_all($sformatf("rand%0d", i), 1'b1, m_a[m_k], m_b[m_k],
                        (m_k == 0), (m_k == W - 1), (m_k == W - 1));
            end else begin
                chk_all($sformatf("rand%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            end
            lv   = ($urandom_range(0, 3) != 0);
            a_in = W'($urandom);
            b_in = W'($urandom);
            m_ready = !m_busy || (m_k == W - 1);
            if (m_ready && lv) begin
                m_busy = 1'b1;
                m_k    = 0;
                m_a    = a_in;
                m_b    = b_in;
                $display("rand load a=%02h b=%02h", a_in, b_in);
            end else if (m_busy && m_k < W - 1) begin
                m_k++;
            end else begin
                m_busy = 1'b0;
            end
        end
        lv = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
